ram_bank_arbiter: RTL

//  Two-requester round-robin arbiter and access sequencer for the four-bank 32x32 RAM array.

---
 rtl/ram_bank_arbiter.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ram_bank_arbiter.sv
// ram_bank_arbiter: two-requester round-robin arbiter and access sequencer for a
// four-bank word RAM. It serialises reads and writes, drives the bank strobes and returns completions.

module ram_bank_arbiter_chk (
  input logic       clk,
  input logic       rst,
  input logic       gnt_a,
  input logic       gnt_b,
  input logic       done_a,
  input logic       done_b,
  input logic [3:0] mem_cs,
  input logic       mem_rw,
  input logic       busy
);

  a_gnt_excl: assert property (@(posedge clk) disable iff (rst) !(gnt_a && gnt_b));
  a_done_excl: assert property (@(posedge clk) disable iff (rst) !(done_a && done_b));
  a_cs_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(mem_cs));
  a_cs_busy: assert property (@(posedge clk) disable iff (rst) (mem_cs != 4'b0000) |-> busy);
  a_rw_cs: assert property (@(posedge clk) disable iff (rst) mem_rw |-> (mem_cs != 4'b0000));

endmodule

module ram_bank_arbiter #(
  parameter int N     = 32,
  parameter int M     = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             we_a,
  input  logic [M+1:0]     addr_a,
  input  logic [N-1:0]     wdata_a,
  output logic             gnt_a,
  output logic             done_a,
  output logic [N-1:0]     rdata_a,
  input  logic             req_b,
  input  logic             we_b,
  input  logic [M+1:0]     addr_b,
  input  logic [N-1:0]     wdata_b,
  output logic             gnt_b,
  output logic             done_b,
  output logic [N-1:0]     rdata_b,
  output logic [3:0]       mem_cs,
  output logic             mem_rw,
  output logic [M-1:0]     mem_addr,
  output logic [N-1:0]     mem_wdata,
  input  logic [N-1:0]     mem_rdata,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  function automatic logic [3:0] bank_onehot(input logic [1:0] bank);
    logic [3:0] oh;
    case (bank)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] res;
    if (cnt == {CNT_W{1'b1}}) begin
      res = cnt;
    end else begin
      res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  state_t           state_q, state_d;
  logic             ptr_b_q, ptr_b_d;
  logic             owner_b_q, owner_b_d;
  logic             we_q, we_d;
  logic [3:0]       mem_cs_q, mem_cs_d;
  logic             mem_rw_q, mem_rw_d;
  logic [M-1:0]     mem_addr_q, mem_addr_d;
  logic [N-1:0]     mem_wdata_q, mem_wdata_d;
  logic             done_a_q, done_a_d;
  logic             done_b_q, done_b_d;
  logic [N-1:0]     rdata_a_q, rdata_a_d;
  logic [N-1:0]     rdata_b_q, rdata_b_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  logic             idle_s;
  logic             win_a_s;
  logic             win_b_s;
  logic             sel_we_s;
  logic [M+1:0]     sel_addr_s;
  logic [N-1:0]     sel_wdata_s;

  assign idle_s = (state_q == S_IDLE);

  // A lone request always wins; on a tie the pointer picks the favoured side
  always_comb begin
    win_a_s = 1'b0;
    win_b_s = 1'b0;
    if (req_a && req_b) begin
      win_a_s = ~ptr_b_q;
      win_b_s = ptr_b_q;
    end else begin
      win_a_s = req_a;
      win_b_s = req_b;
    end
  end

  always_comb begin
    sel_we_s    = we_a;
    sel_addr_s  = addr_a;
    sel_wdata_s = wdata_a;
    if (win_b_s) begin
      sel_we_s    = we_b;
      sel_addr_s  = addr_b;
      sel_wdata_s = wdata_b;
    end else begin
      sel_we_s    = we_a;
      sel_addr_s  = addr_a;
      sel_wdata_s = wdata_a;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_b_d     = ptr_b_q;
    owner_b_d   = owner_b_q;
    we_d        = we_q;
    mem_cs_d    = 4'b0000;
    mem_rw_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_a_d    = 1'b0;
    done_b_d    = 1'b0;
    rdata_a_d   = rdata_a_q;
    rdata_b_d   = rdata_b_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;
    case (state_q)
      S_IDLE: begin
        if (win_a_s || win_b_s) begin
          state_d     = S_ISSUE;
          owner_b_d   = win_b_s;
          we_d        = sel_we_s;
          mem_cs_d    = bank_onehot(sel_addr_s[M+1:M]);
          mem_rw_d    = sel_we_s;
          mem_addr_d  = sel_addr_s[M-1:0];
          mem_wdata_d = sel_wdata_s;
          if (win_b_s) begin
            cnt_b_d = sat_inc(cnt_b_q);
          end else begin
            cnt_a_d = sat_inc(cnt_a_q);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        // A write completes on this edge; a read keeps the bank selected one more cycle
        if (we_q) begin
          state_d  = S_DONE;
          done_a_d = ~owner_b_q;
          done_b_d = owner_b_q;
        end else begin
          state_d  = S_CAPTURE;
          mem_cs_d = mem_cs_q;
          mem_rw_d = 1'b0;
        end
      end
      S_CAPTURE: begin
        state_d  = S_DONE;
        done_a_d = ~owner_b_q;
        done_b_d = owner_b_q;
        if (owner_b_q) begin
          rdata_b_d = mem_rdata;
        end else begin
          rdata_a_d = mem_rdata;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ptr_b_d = ~owner_b_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_b_q     <= 1'b0;
      owner_b_q   <= 1'b0;
      we_q        <= 1'b0;
      mem_cs_q    <= 4'b0000;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_a_q    <= 1'b0;
      done_b_q    <= 1'b0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_b_q     <= ptr_b_d;
      owner_b_q   <= owner_b_d;
      we_q        <= we_d;
      mem_cs_q    <= mem_cs_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_a_q    <= done_a_d;
      done_b_q    <= done_b_d;
      rdata_a_q   <= rdata_a_d;
      rdata_b_q   <= rdata_b_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
    end
  end

  // Grants are combinational so the request fields latch on the same edge; gated off in reset
  assign gnt_a     = idle_s & win_a_s & ~rst;
  assign gnt_b     = idle_s & win_b_s & ~rst;
  assign done_a    = done_a_q;
  assign done_b    = done_b_q;
  assign rdata_a   = rdata_a_q;
  assign rdata_b   = rdata_b_q;
  assign mem_cs    = mem_cs_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = ~idle_s;
  assign cnt_a     = cnt_a_q;
  assign cnt_b     = cnt_b_q;

  ram_bank_arbiter_chk u_chk (
    .clk    (clk),
    .rst    (rst),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .done_a (done_a),
    .done_b (done_b),
    .mem_cs (mem_cs),
    .mem_rw (mem_rw),
    .busy   (busy)
  );

endmodule
